bram_port_seq: RTL

- Sequencer that sits directly upstream of the dual-port BRAM top (port 0 plus its output register) and drives it.
- Write job: accepts a valid/ready input stream and writes a block of words to consecutive addresses.
- Read job: reads a block back and emits it as a valid/ready output stream.
- Absorbs the 2-cycle BRAM+output-register read latency with a small skid FIFO, so the output stream can be backpressured.

---
 rtl/bram_port_seq_if.sv | 28 ++
 rtl/bram_port_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bram_port_seq_if.sv
// rtl/bram_port_seq_if.sv - stream and BRAM port-0 signals between sequencer and its neighbours
interface bram_port_seq_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [ADDR_WIDTH-1:0] addr0_b0;
   logic                  ce0_b0;
   logic                  we0_b0;
   logic [DATA_WIDTH-1:0] d0_b0;
   logic                  reg_en;
   logic [DATA_WIDTH-1:0] reg_out;

   modport master (
      input  s_valid, s_data, m_ready, reg_out,
      output s_ready, m_valid, m_data, addr0_b0, ce0_b0, we0_b0, d0_b0, reg_en
   );

   modport slave (
      output s_valid, s_data, m_ready, reg_out,
      input  s_ready, m_valid, m_data, addr0_b0, ce0_b0, we0_b0, d0_b0, reg_en
   );
endinterface

// File: rtl/bram_port_seq.sv
// rtl/bram_port_seq.sv - block write/read sequencer for BRAM port 0 with output skid FIFO
module bram_port_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_wr,
   input  logic                  start_rd,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_words,
   output logic                  busy,
   output logic                  done,
   bram_port_seq_if.master       bus
);
   localparam int CW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [1:0]            r_pipe;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [CW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_rd_ptr;
   logic [CW:0]           r_count;

   logic        w_wr_fire;
   logic        w_rd_fire;
   logic        w_ce;
   logic [1:0]  w_inflight;
   logic        w_credit;
   logic        w_push;
   logic        w_pop;
   logic        w_m_valid;
   logic        w_last;

   // Reads are only issued while every in-flight word is guaranteed a FIFO slot.
   assign w_inflight = {1'b0, r_pipe[0]} + {1'b0, r_pipe[1]};
   assign w_credit   = ({1'b0, r_count} + {{CW{1'b0}}, w_inflight}) < (CW+2)'(FIFO_DEPTH);
   assign w_wr_fire  = (r_state == S_WRITE) && bus.s_valid;
   assign w_rd_fire  = (r_state == S_READ) && w_credit;
   assign w_ce       = w_wr_fire || w_rd_fire;
   assign w_push     = r_pipe[1];
   assign w_m_valid  = (r_count != '0);
   assign w_pop      = w_m_valid && bus.m_ready;
   assign w_last     = (r_remaining == (ADDR_WIDTH+1)'(1));

   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_FIN);
   assign bus.s_ready  = (r_state == S_WRITE);
   assign bus.ce0_b0   = w_ce;
   assign bus.we0_b0   = w_wr_fire;
   assign bus.addr0_b0 = w_ce ? r_addr : '0;
   assign bus.d0_b0    = w_wr_fire ? bus.s_data : '0;
   assign bus.reg_en   = r_pipe[0];
   assign bus.m_valid  = w_m_valid;
   assign bus.m_data   = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_wr || start_rd) begin
                  r_addr      <= base_addr;
                  r_remaining <= num_words;
                  if (num_words == '0)
                     r_state <= S_FIN;
                  else if (start_wr)
                     r_state <= S_WRITE;
                  else
                     r_state <= S_READ;
               end
            end
            S_WRITE: begin
               if (w_wr_fire) begin
                  r_addr      <= r_addr + 1'b1;
                  r_remaining <= r_remaining - 1'b1;
                  if (w_last)
                     r_state <= S_FIN;
               end
            end
            S_READ: begin
               if (w_rd_fire) begin
                  r_addr      <= r_addr + 1'b1;
                  r_remaining <= r_remaining - 1'b1;
                  if (w_last)
                     r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_pipe == 2'b00 && r_count == '0)
                  r_state <= S_FIN;
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stage 0 valid means the BRAM is presenting data (reg_en); stage 1 means reg_out holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         r_pipe <= {r_pipe[0], w_rd_fire};
         if (w_push) begin
            r_mem[r_wr_ptr] <= bus.reg_out;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
